// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction adds the nines' complement of B with the carry preset to 1.
module bcd_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  input  logic                   sub,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   err,
  output logic                   out_valid,
  input  logic                   out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and DONE holds
  // its outputs until out_ready is sampled high.

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            sub_r;
  logic [IW-1:0]   idx;
  logic            carry;

  logic [3:0]      a_d;
  logic [3:0]      b_d;
  logic [3:0]      bd;
  logic [4:0]      t;
  logic [3:0]      digit;
  logic            c_next;
  logic            bad;
  logic            last;

  always_comb begin
    a_d    = a_r[4*idx +: 4];
    b_d    = b_r[4*idx +: 4];
    bd     = sub_r ? (4'd9 - b_d) : b_d;
    t      = {1'b0, a_d} + {1'b0, bd} + {4'd0, carry};
    digit  = t[3:0];
    c_next = 1'b0;
    // Decimal correction; the 4-bit wrap of +6 equals (t+6)[3:0].
    if (t > 5'd9) begin
      digit  = t[3:0] + 4'd6;
      c_next = 1'b1;
    end
    bad  = (a_d > 4'd9) || (b_d > 4'd9);
    last = (idx == IW'(NDIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      carry     <= 1'b0;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            sub_r    <= sub;
            idx      <= '0;
            sum      <= '0;
            err      <= 1'b0;
            carry    <= sub;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= digit;
          carry           <= c_next;
          err             <= err | bad;
          if (last) begin
            cout      <= c_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: NDIGITS=4, 1 and 16 instances, scoreboard against
// an integer decimal model, directed cases plus a random 16-digit sweep.
module tb_bcd_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a_drv = '0;
  logic [63:0] b_drv = '0;
  logic        sub_drv = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  sel = 2'd0;

  logic [15:0] sum4;
  logic [3:0]  sum1;
  logic [63:0] sum16;
  logic [2:0]  ir, ov, co, er;

  logic [63:0] cur_sum;
  logic        cur_in_ready, cur_out_valid, cur_cout, cur_err;

  int errors = 0;
  int checks = 0;
  logic [65:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_serial_addsub #(.NDIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .a(a_drv[15:0]), .b(b_drv[15:0]), .sub(sub_drv),
    .in_valid(in_valid && sel == 2'd0), .in_ready(ir[0]), .sum(sum4),
    .cout(co[0]), .err(er[0]), .out_valid(ov[0]), .out_ready(out_ready && sel == 2'd0));

  bcd_serial_addsub #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .a(a_drv[3:0]), .b(b_drv[3:0]), .sub(sub_drv),
    .in_valid(in_valid && sel == 2'd1), .in_ready(ir[1]), .sum(sum1),
    .cout(co[1]), .err(er[1]), .out_valid(ov[1]), .out_ready(out_ready && sel == 2'd1));

  bcd_serial_addsub #(.NDIGITS(16)) dut16 (
    .clk(clk), .rst(rst), .a(a_drv), .b(b_drv), .sub(sub_drv),
    .in_valid(in_valid && sel == 2'd2), .in_ready(ir[2]), .sum(sum16),
    .cout(co[2]), .err(er[2]), .out_valid(ov[2]), .out_ready(out_ready && sel == 2'd2));

  always_comb begin
    cur_sum = '0;
    case (sel)
      2'd0:    cur_sum = {48'd0, sum4};
      2'd1:    cur_sum = {60'd0, sum1};
      default: cur_sum = sum16;
    endcase
    cur_in_ready  = ir[sel];
    cur_out_valid = ov[sel];
    cur_cout      = co[sel];
    cur_err       = er[sel];
  end

  function automatic int ndig(input logic [1:0] s);
    return (s == 2'd0) ? 4 : (s == 2'd1) ? 1 : 16;
  endfunction

  function automatic longint unsigned bcd2int(input logic [63:0] v, input int n);
    longint unsigned r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + 64'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint unsigned v, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Returns {err, cout, sum}; only meaningful for valid BCD operands.
  function automatic logic [65:0] model(input int n, input logic [63:0] av,
                                        input logic [63:0] bv, input logic s);
    longint unsigned x, y, m, r;
    logic c;
    x = bcd2int(av, n);
    y = bcd2int(bv, n);
    m = 1;
    for (int i = 0; i < n; i++) m = m * 10;
    if (!s) begin
      r = x + y;
      c = (r >= m);
      if (c) r = r - m;
    end else begin
      c = (x >= y);
      r = c ? (x - y) : (m + x - y);
    end
    return {1'b0, c, int2bcd(r, n)};
  endfunction

  function automatic logic [63:0] rand_bcd(input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic s);
    int tries = 0;
    a_drv    = av;
    b_drv    = bv;
    sub_drv  = s;
    in_valid = 1'b1;
    while (!cur_in_ready && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!cur_in_ready) check("accept_timeout", 64'(cur_in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges to out_valid while scrambling the inputs, then scores the result.
  task automatic wait_result(output logic [65:0] e);
    int lat = 0;
    logic got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (cur_out_valid) begin
        got      = 1'b1;
        in_valid = 1'b0;
      end else begin
        a_drv    = {$urandom, $urandom};
        b_drv    = {$urandom, $urandom};
        sub_drv  = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(ndig(sel)));
    if (exp_q.size() == 0) begin
      e = '0;
      check("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("sum",  cur_sum,         e[63:0]);
      check("cout", 64'(cur_cout),   64'(e[64]));
      check("err",  64'(cur_err),    64'(e[65]));
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic drive_exp(input logic [63:0] av, input logic [63:0] bv,
                           input logic s, input logic [65:0] e);
    logic [65:0] got_e;
    exp_q.push_back(e);
    start_op(av, bv, s);
    wait_result(got_e);
    handshake();
  endtask

  task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic s);
    drive_exp(av, bv, s, model(ndig(sel), av, bv, s));
  endtask

  initial begin
    logic [65:0] e;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(cur_in_ready),  64'd1);
    check("rst_out_valid", 64'(cur_out_valid), 64'd0);
    check("rst_sum",       cur_sum,            64'd0);
    check("rst_cout",      64'(cur_cout),      64'd0);
    check("rst_err",       64'(cur_err),       64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed NDIGITS=4 cases
    sel = 2'd0;
    drive_exp(64'h1234, 64'h8766, 1'b0, {1'b0, 1'b1, 64'h0000});
    drive(64'h1234, 64'h8766, 1'b0);
    drive_exp(64'h5000, 64'h0001, 1'b1, {1'b0, 1'b1, 64'h4999});
    drive_exp(64'h0001, 64'h0002, 1'b1, {1'b0, 1'b0, 64'h9999});
    drive(64'h0731, 64'h0731, 1'b1);
    drive(64'h9999, 64'h9999, 1'b0);
    drive_exp(64'h00A0, 64'h0000, 1'b0, {1'b1, 1'b0, 64'h0100});
    drive(64'h0042, 64'h0017, 1'b0);

    // Backpressure in DONE
    exp_q.push_back(model(4, 64'h2468, 64'h1357, 1'b0));
    start_op(64'h2468, 64'h1357, 1'b0);
    wait_result(e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(cur_out_valid), 64'd1);
      check("bp_in_ready",  64'(cur_in_ready),  64'd0);
      check("bp_sum",       cur_sum,            e[63:0]);
      check("bp_cout",      64'(cur_cout),      64'(e[64]));
    end
    handshake();
    check("bp_idle_in_ready",  64'(cur_in_ready),  64'd1);
    check("bp_idle_out_valid", 64'(cur_out_valid), 64'd0);

    // Reset on the second RUN cycle
    start_op(64'h9876, 64'h1111, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready",  64'(cur_in_ready),  64'd1);
    check("mid_rst_out_valid", 64'(cur_out_valid), 64'd0);
    check("mid_rst_sum",       cur_sum,            64'd0);
    check("mid_rst_cout",      64'(cur_cout),      64'd0);
    check("mid_rst_err",       64'(cur_err),       64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_output", 64'(cur_out_valid), 64'd0);
    end
    drive(64'h3090, 64'h4915, 1'b1);

    // NDIGITS=1
    sel = 2'd1;
    @(posedge clk); #1;
    drive_exp(64'h9, 64'h9, 1'b0, {1'b0, 1'b1, 64'h8});
    drive(64'h3, 64'h7, 1'b1);

    // NDIGITS=16 random sweep
    sel = 2'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++)
      drive(rand_bcd(16), rand_bcd(16), 1'($urandom_range(0, 1)));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
